// File: rtl/car_power_ctrl.sv
// car_power_ctrl: power/drive-mode sequencer with held-button power control and detector latch-off.
// Define AUTO_MODE_EN to make mode_req=11 (auto) a legal request.
module car_power_ctrl #(
  parameter int HOLD_CYCLES = 100,
  parameter int ARM_DELAY   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_btn,
  input  logic [1:0] mode_req,
  input  logic       mode_valid,
  input  logic       moving,
  input  logic       no_barrier_off,
  output logic       power_on,
  output logic       detect_start,
  output logic [1:0] mode,
  output logic       mode_ack,
  output logic       mode_err,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    OFF       = 3'd0,
    PWR_UP    = 3'd1,
    ARMING    = 3'd2,
    ON        = 3'd3,
    PWR_DOWN  = 3'd4,
    LATCH_OFF = 3'd5
  } state_t;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] ARM_LAST  = 16'(ARM_DELAY - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic        power_on_q, power_on_d;
  logic        detect_start_q, detect_start_d;
  logic        mode_ack_q, mode_ack_d;
  logic        mode_err_q, mode_err_d;
  logic        legal, mode_eval, accept;
`ifdef AUTO_MODE_EN
  assign legal = mode_req != 2'b00;
`else
  assign legal = mode_req != 2'b00 && mode_req != 2'b11;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OFF:       if (power_btn) begin state_d = PWR_UP; cnt_d = 16'd1; end
      PWR_UP:
        if (!power_btn) state_d = OFF;
        else if (cnt_q == HOLD_LAST) begin state_d = ARMING; cnt_d = '0; end
        else cnt_d = cnt_q + 16'd1;
      // Counter parks at the last arming cycle so a held button only delays the exit.
      ARMING:
        if (cnt_q == ARM_LAST && !power_btn) state_d = ON;
        else if (cnt_q != ARM_LAST) cnt_d = cnt_q + 16'd1;
      ON:
        if (no_barrier_off) state_d = LATCH_OFF;
        else if (power_btn) begin state_d = PWR_DOWN; cnt_d = 16'd1; end
      PWR_DOWN:
        if (no_barrier_off || (power_btn && cnt_q == HOLD_LAST)) state_d = LATCH_OFF;
        else if (!power_btn) state_d = ON;
        else cnt_d = cnt_q + 16'd1;
      LATCH_OFF: if (!power_btn) state_d = OFF;
      default:   begin state_d = OFF; cnt_d = '0; end
    endcase
  end
  // Requests are dropped when the car is latching off in the same cycle.
  always_comb begin
    mode_eval      = (state_q == ON || state_q == PWR_DOWN) && mode_valid && state_d != LATCH_OFF;
    accept         = mode_eval && legal && !moving;
    mode_ack_d     = accept;
    mode_err_d     = mode_eval && !accept;
    mode_d         = (state_d == OFF || state_d == LATCH_OFF) ? 2'b00 : accept ? mode_req : mode_q;
    power_on_d     = state_d == ARMING || state_d == ON || state_d == PWR_DOWN;
    detect_start_d = state_d == ON || state_d == PWR_DOWN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= OFF;
      cnt_q          <= '0;
      mode_q         <= 2'b00;
      power_on_q     <= 1'b0;
      detect_start_q <= 1'b0;
      mode_ack_q     <= 1'b0;
      mode_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      power_on_q     <= power_on_d;
      detect_start_q <= detect_start_d;
      mode_ack_q     <= mode_ack_d;
      mode_err_q     <= mode_err_d;
    end
  end
  assign power_on     = power_on_q;
  assign detect_start = detect_start_q;
  assign mode         = mode_q;
  assign mode_ack     = mode_ack_q;
  assign mode_err     = mode_err_q;
  assign state        = state_q;
endmodule

// File: tb/tb_car_power_ctrl.sv
// tb_car_power_ctrl: directed test-plan scenarios plus randomized stimulus against a behavioural model.
module tb_car_power_ctrl;
  localparam int HOLD = 4;
  localparam int ARM  = 3;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0, mv = 1'b0, mov = 1'b0, nbo = 1'b0;
  logic [1:0] mr = 2'b00;
  logic       power_on, detect_start, mode_ack, mode_err;
  logic [1:0] mode;
  logic [2:0] state;
  int checks = 0, errors = 0;
  bit m_pwr, m_det, m_lat, eack, eerr;
  int press, armc;
  logic [1:0] em;

  car_power_ctrl #(.HOLD_CYCLES(HOLD), .ARM_DELAY(ARM)) dut (
    .clk(clk), .rst_n(rst_n), .power_btn(btn), .mode_req(mr), .mode_valid(mv),
    .moving(mov), .no_barrier_off(nbo), .power_on(power_on), .detect_start(detect_start),
    .mode(mode), .mode_ack(mode_ack), .mode_err(mode_err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit req_legal(input logic [1:0] r);
`ifdef AUTO_MODE_EN
    return r != 2'b00;
`else
    return r == 2'b01 || r == 2'b10;
`endif
  endfunction

  function automatic logic [7:0] exp_state();
    if (m_lat) return 8'd5;
    if (!m_pwr) return press > 0 ? 8'd1 : 8'd0;
    if (!m_det) return 8'd2;
    return press > 0 ? 8'd4 : 8'd3;
  endfunction

  task automatic mdl_reset();
    m_pwr = 0; m_det = 0; m_lat = 0; eack = 0; eerr = 0; press = 0; armc = 0; em = 2'b00;
  endtask

  // Car-level rules: consecutive press count, cycles spent arming, latch until release.
  task automatic mdl_step();
    bit off;
    eack = 0;
    eerr = 0;
    if (m_lat) begin
      if (!btn) m_lat = 0;
    end else if (!m_pwr) begin
      press = btn ? press + 1 : 0;
      if (press == HOLD) begin m_pwr = 1; armc = 0; press = 0; end
    end else if (!m_det) begin
      armc++;
      if (armc >= ARM && !btn) m_det = 1;
    end else begin
      off = nbo || (btn && press + 1 == HOLD);
      if (mv && !off) begin
        if (req_legal(mr) && !mov) begin em = mr; eack = 1; end
        else eerr = 1;
      end
      if (off) begin m_pwr = 0; m_det = 0; m_lat = 1; press = 0; em = 2'b00; end
      else press = btn ? press + 1 : 0;
    end
  endtask

  task automatic compare();
    check("power_on", 8'(power_on), 8'(m_pwr));
    check("detect_start", 8'(detect_start), 8'(m_det));
    check("mode", 8'(mode), 8'(em));
    check("mode_ack", 8'(mode_ack), 8'(eack));
    check("mode_err", 8'(mode_err), 8'(eerr));
    check("state", 8'(state), exp_state());
    check("ack_err_excl", 8'(mode_ack & mode_err), 8'd0);
  endtask

  task automatic step();
    @(posedge clk);
    mdl_step();
    #1;
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic power_up();
    btn = 1; steps(HOLD);
    btn = 0; steps(ARM);
  endtask

  initial begin
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    check("reset_state", 8'(state), 8'd0);
    rst_n = 1;
    steps(2);
    // Power-on
    btn = 1; steps(HOLD);
    check("pwr_on_rise", 8'(power_on), 8'd1);
    check("arming_state", 8'(state), 8'd2);
    btn = 0; steps(ARM - 1);
    check("det_not_yet", 8'(detect_start), 8'd0);
    step();
    check("det_rise", 8'(detect_start), 8'd1);
    check("on_state", 8'(state), 8'd3);
    // Mode arbitration
    mv = 1; mr = 2'b10; mov = 0; step();
    mv = 0;
    check("mode_semi", 8'(mode), 8'd2);
    check("semi_ack", 8'(mode_ack), 8'd1);
    step();
    check("ack_one_cycle", 8'(mode_ack), 8'd0);
    mv = 1; mr = 2'b01; mov = 1; step();
    mv = 0; mov = 0;
    check("moving_err", 8'(mode_err), 8'd1);
    check("moving_mode_kept", 8'(mode), 8'd2);
    mv = 1; mr = 2'b00; step();
    mv = 0;
    check("illegal_err", 8'(mode_err), 8'd1);
    mv = 1; mr = 2'b11; step();
    mv = 0;
`ifdef AUTO_MODE_EN
    check("auto_mode", 8'(mode), 8'd3);
    check("auto_ack", 8'(mode_ack), 8'd1);
`else
    check("auto_mode", 8'(mode), 8'd2);
    check("auto_err", 8'(mode_err), 8'd1);
`endif
    // Short button press in ON returns to ON
    btn = 1; steps(2);
    check("pwr_down_state", 8'(state), 8'd4);
    btn = 0; step();
    check("back_on_state", 8'(state), 8'd3);
    // Button power-off
    btn = 1; steps(HOLD);
    check("btn_off_power", 8'(power_on), 8'd0);
    check("btn_off_state", 8'(state), 8'd5);
    steps(2);
    check("latch_held", 8'(state), 8'd5);
    btn = 0; step();
    check("latch_release", 8'(state), 8'd0);
    // Short press from OFF
    btn = 1; steps(HOLD - 1);
    btn = 0; step();
    check("short_press_state", 8'(state), 8'd0);
    check("short_press_power", 8'(power_on), 8'd0);
    // Detector timeout with simultaneous mode request and button
    power_up();
    mv = 1; mr = 2'b01; nbo = 1; btn = 1; step();
    mv = 0; nbo = 0;
    check("nbo_power", 8'(power_on), 8'd0);
    check("nbo_mode", 8'(mode), 8'd0);
    check("nbo_state", 8'(state), 8'd5);
    check("nbo_no_ack", 8'(mode_ack | mode_err), 8'd0);
    step();
    btn = 0; step();
    check("nbo_release", 8'(state), 8'd0);
    // Reset mid-ON
    power_up();
    mv = 1; mr = 2'b10; step();
    mv = 0;
    #2 rst_n = 0;
    #1;
    mdl_reset();
    check("rst_power_on", 8'(power_on), 8'd0);
    check("rst_detect", 8'(detect_start), 8'd0);
    check("rst_mode", 8'(mode), 8'd0);
    check("rst_state", 8'(state), 8'd0);
    @(posedge clk);
    #1 rst_n = 1;
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) btn = ~btn;
      nbo = $urandom_range(0, 99) == 0;
      mv  = $urandom_range(0, 3) == 0;
      mr  = 2'($urandom_range(0, 3));
      mov = $urandom_range(0, 2) == 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
